// File: rtl/genreg_pkg.sv
// ----------------------------------------------------------------------------
// genreg_pkg : field positions and state encoding for the genreg responder.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package genreg_pkg;

  localparam int GENREG_GO_BIT   = 31;
  localparam int GENREG_WR_BIT   = 30;
  localparam int GENREG_ADDR_MSB = 15;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TMO      = 2;
  localparam int ST_OVR      = 3;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_CNT_MSB  = 15;
  localparam int ST_ADDR_LSB = 16;
  localparam int ST_ADDR_MSB = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } genreg_state_e;

endpackage

`default_nettype wire

// File: rtl/genreg_responder.sv
// ----------------------------------------------------------------------------
// genreg_responder : runs one req/ack bus transaction per go-bit toggle.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module genreg_responder
  import genreg_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       genreg_addr_ctrl,
  input  logic [31:0]       genreg_wr_data,
  output logic [31:0]       genreg_rd_data,
  output logic [31:0]       genreg_status,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  genreg_state_e     state_q, state_d;
  logic              go_q, go_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       last_addr_q, last_addr_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;

  logic [GENREG_ADDR_MSB:0] addr_field;
  logic                     go_bit;
  logic                     toggle;
  logic [15:0]              addr_ext;
  logic                     unused_ctrl;

  assign addr_field  = genreg_addr_ctrl[GENREG_ADDR_MSB:0];
  assign go_bit      = genreg_addr_ctrl[GENREG_GO_BIT];
  assign toggle      = (go_bit != go_q);
  assign unused_ctrl = ^{genreg_addr_ctrl[29:16], addr_field};

  always_comb begin
    addr_ext               = '0;
    addr_ext[ADDR_W-1:0]   = addr_q;
  end

  always_comb begin
    state_d     = state_q;
    go_d        = go_q;
    req_d       = req_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    tmo_d       = tmo_q;
    ovr_d       = ovr_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (toggle) begin
          go_d      = go_bit;
          state_d   = REQ;
          req_d     = 1'b1;
          wr_d      = genreg_addr_ctrl[GENREG_WR_BIT];
          addr_d    = addr_field[ADDR_W-1:0];
          wdata_d   = genreg_wr_data;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          tmo_d     = 1'b0;
          ovr_d     = 1'b0;
          tmo_cnt_d = 16'd1;
        end
      end
      REQ: begin
        if (toggle) begin
          go_d  = go_bit;
          ovr_d = 1'b1;
        end
        // An ack in the expiry cycle takes priority over the timeout.
        if (bus_ack || (tmo_cnt_q == TMO_LIM)) begin
          state_d     = DONE;
          req_d       = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          last_addr_d = addr_ext;
          tmo_cnt_d   = 16'd0;
          if (bus_ack) begin
            if (!wr_q) rd_data_d = bus_rdata;
          end else begin
            tmo_d = 1'b1;
            if (!wr_q) rd_data_d = ERR_PATTERN;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (toggle) begin
          go_d  = go_bit;
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    genreg_status                            = '0;
    genreg_status[ST_BUSY]                   = busy_q;
    genreg_status[ST_DONE]                   = done_q;
    genreg_status[ST_TMO]                    = tmo_q;
    genreg_status[ST_OVR]                    = ovr_q;
    genreg_status[ST_CNT_MSB:ST_CNT_LSB]     = cnt_q;
    genreg_status[ST_ADDR_MSB:ST_ADDR_LSB]   = last_addr_q;
  end

  assign genreg_rd_data = rd_data_q;
  assign bus_req        = req_q;
  assign bus_wr         = wr_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_genreg_responder.sv
// ----------------------------------------------------------------------------
// tb_genreg_responder : directed checks of the genreg responder, TIMEOUT_CYC=8.
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_genreg_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] genreg_addr_ctrl = '0;
  logic [31:0] genreg_wr_data = '0;
  logic [31:0] genreg_rd_data;
  logic [31:0] genreg_status;
  logic        bus_req;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int req_pulses = 0;

  always #5 clk = ~clk;

  always @(posedge bus_req) req_pulses++;

  genreg_responder #(
    .ADDR_W      (16),
    .TIMEOUT_CYC (8),
    .ERR_PATTERN (32'hDEAD_BEEF)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .genreg_addr_ctrl (genreg_addr_ctrl),
    .genreg_wr_data   (genreg_wr_data),
    .genreg_rd_data   (genreg_rd_data),
    .genreg_status    (genreg_status),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_rdata        (bus_rdata),
    .bus_ack          (bus_ack)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: got %b expected 0", bus_req);
    end
    vectors++;
    if (genreg_status !== 32'h0) begin
      miscompares++; $display("FAIL reset_status: got %h expected 00000000", genreg_status);
    end
    vectors++;
    if (genreg_rd_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_rd_data: got %h expected 00000000", genreg_rd_data);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus_req !== 1'b0 || genreg_status !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got req=%b status=%h expected req=0 status=00000000",
               bus_req, genreg_status);
    end
  endtask

  task automatic test_write();
    genreg_wr_data   = 32'h1234_5678;
    genreg_addr_ctrl = 32'hC000_0042;
    @(negedge clk);
    vectors++;
    if ({bus_req, bus_wr} !== 2'b11) begin
      miscompares++; $display("FAIL wr_req_wr: got %b expected 11", {bus_req, bus_wr});
    end
    vectors++;
    if (bus_addr !== 16'h0042 || bus_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wr_addr_data: got %h/%h expected 0042/12345678", bus_addr, bus_wdata);
    end
    vectors++;
    if (genreg_status !== 32'h0000_0001) begin
      miscompares++; $display("FAIL wr_busy: got %h expected 00000001", genreg_status);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++; $display("FAIL wr_req_held: got %b expected 1", bus_req);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    vectors++;
    if (bus_req !== 1'b0) begin
      miscompares++; $display("FAIL wr_req_drop: got %b expected 0", bus_req);
    end
    vectors++;
    if (genreg_status !== 32'h0042_0102) begin
      miscompares++; $display("FAIL wr_status: got %h expected 00420102", genreg_status);
    end
    vectors++;
    if (genreg_rd_data !== 32'h0) begin
      miscompares++; $display("FAIL wr_rd_data: got %h expected 00000000", genreg_rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_read();
    genreg_addr_ctrl = 32'h0000_0010;
    @(negedge clk);
    vectors++;
    if ({bus_req, bus_wr} !== 2'b10 || bus_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL rd_req: got req/wr=%b addr=%h expected 10/0010", {bus_req, bus_wr}, bus_addr);
    end
    vectors++;
    if (genreg_status !== 32'h0042_0101) begin
      miscompares++; $display("FAIL rd_busy: got %h expected 00420101", genreg_status);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    vectors++;
    if (genreg_rd_data !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL rd_data: got %h expected cafef00d", genreg_rd_data);
    end
    vectors++;
    if (genreg_status !== 32'h0010_0202) begin
      miscompares++; $display("FAIL rd_status: got %h expected 00100202", genreg_status);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    genreg_addr_ctrl = 32'h8000_0020;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_req) hi++;
      else if (hi > 0) break;
    end
    vectors++;
    if (hi !== 8) begin
      miscompares++; $display("FAIL tmo_req_cycles: got %0d expected 8", hi);
    end
    vectors++;
    if (genreg_rd_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL tmo_rd_data: got %h expected deadbeef", genreg_rd_data);
    end
    vectors++;
    if (genreg_status !== 32'h0020_0306) begin
      miscompares++; $display("FAIL tmo_status: got %h expected 00200306", genreg_status);
    end
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h9999_9999;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);
    vectors++;
    if (genreg_rd_data !== 32'hDEAD_BEEF || genreg_status !== 32'h0020_0306 || bus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_ignored: got rd=%h st=%h req=%b expected deadbeef/00200306/0",
               genreg_rd_data, genreg_status, bus_req);
    end
  endtask

  task automatic test_overrun();
    int p0;
    p0 = req_pulses;
    genreg_addr_ctrl = 32'h0000_0030;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++; $display("FAIL ovr_req: got %b expected 1", bus_req);
    end
    genreg_addr_ctrl = 32'h8000_0030;
    @(negedge clk);
    vectors++;
    if (genreg_status[3] !== 1'b1) begin
      miscompares++; $display("FAIL ovr_flag: got %b expected 1", genreg_status[3]);
    end
    genreg_addr_ctrl = 32'h0000_0030;
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    vectors++;
    if (genreg_status !== 32'h0030_040A || genreg_rd_data !== 32'h1111_2222) begin
      miscompares++;
      $display("FAIL ovr_done: got st=%h rd=%h expected 0030040a/11112222",
               genreg_status, genreg_rd_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_req !== 1'b0 || (req_pulses - p0) !== 1) begin
      miscompares++;
      $display("FAIL ovr_single_pulse: got req=%b pulses=%0d expected 0/1", bus_req, req_pulses - p0);
    end
    genreg_addr_ctrl = 32'h8000_0040;
    @(negedge clk);
    vectors++;
    if (genreg_status !== 32'h0030_0401) begin
      miscompares++; $display("FAIL ovr_cleared: got %h expected 00300401", genreg_status);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_0055;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    vectors++;
    if (genreg_status !== 32'h0040_0502) begin
      miscompares++; $display("FAIL ovr_next_done: got %h expected 00400502", genreg_status);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    genreg_addr_ctrl = 32'h0000_0050;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++; $display("FAIL mid_req_start: got %b expected 1", bus_req);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus_req !== 1'b0 || genreg_status !== 32'h0 || genreg_rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_req_reset: got req=%b st=%h rd=%h expected 0/00000000/00000000",
               bus_req, genreg_status, genreg_rd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus_req !== 1'b0 || genreg_status !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_req_no_restart: got req=%b st=%h expected 0/00000000", bus_req, genreg_status);
    end
  endtask

  task automatic test_count_wrap();
    logic go;
    go = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      go = ~go;
      genreg_addr_ctrl = {go, 1'b1, 14'h0, 16'(n)};
      genreg_wr_data   = n;
      @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      @(negedge clk);
      if (n == 1) begin
        vectors++;
        if (genreg_status !== 32'h0001_0102) begin
          miscompares++; $display("FAIL wrap_first: got %h expected 00010102", genreg_status);
        end
      end
      if (n == 255) begin
        vectors++;
        if (genreg_status[15:8] !== 8'hFF) begin
          miscompares++; $display("FAIL wrap_ff: got %h expected ff", genreg_status[15:8]);
        end
      end
    end
    vectors++;
    if (genreg_status[15:8] !== 8'h00 || genreg_status[31:16] !== 16'h0100) begin
      miscompares++;
      $display("FAIL wrap_zero: got cnt=%h addr=%h expected 00/0100",
               genreg_status[15:8], genreg_status[31:16]);
    end
    vectors++;
    if (genreg_rd_data !== 32'h0) begin
      miscompares++; $display("FAIL wrap_rd_data: got %h expected 00000000", genreg_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_overrun();
    test_reset_mid_req();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
